// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan decoder: segment bit indices,
// the hex glyph table (active-high, bit0 = a) and the blank pattern.
package ssd_pkg;

   typedef enum int unsigned {
      SEG_A = 0,
      SEG_B,
      SEG_C,
      SEG_D,
      SEG_E,
      SEG_F,
      SEG_G,
      SEG_COUNT
   } seg_idx_e;

   localparam int unsigned SEG_W  = SEG_COUNT;
   localparam int unsigned DIGITS = 4;

   localparam logic [SEG_W-1:0] SEG_BLANK = '0;

   // Entry n is the glyph for hex digit n.
   localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational seven-segment pattern classifier: hex hit with nibble, or blank.
module seg7_glyph_decode
   import ssd_pkg::*;
(
   input  logic [SEG_W-1:0] pattern,
   output logic             hit,
   output logic             is_blank,
   output logic [3:0]       nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = '0;
      for (int unsigned g = 0; g < 16; g++) begin
         if (pattern == GLYPH_TABLE[g]) begin
            hit    = 1'b1;
            nibble = 4'(g);
         end
      end
   end

   assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers four hex digits from a multiplexed seven-segment display scan,
// capturing each digit once its segment/enable pattern has been stable long enough.
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEG_W-1:0] ssd,
   input  logic [3:0]       dig,
   output logic [15:0]      value,
   output logic [3:0]       valid,
   output logic [3:0]       blank,
   output logic [3:0]       bad_glyph,
   output logic             frame_strobe,
   output logic [7:0]       scan_err_cnt
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);

   logic [SEG_W-1:0] ssd_in, s_ssd;
   logic [3:0]       dig_in, s_dig;
   logic [7:0]       stab_cnt;
   logic [3:0]       seen;
   logic [3:0]       seen_next;
   logic             dig_in_onehot;
   logic             stable;
   logic             capture;
   logic             s_multi_hot;
   logic             dec_hit;
   logic             dec_blank;
   logic [3:0]       dec_nibble;

   assign ssd_in = SEG_ACTIVE_LOW ? ~ssd : ssd;
   assign dig_in = DIG_ACTIVE_LOW ? ~dig : dig;

   assign dig_in_onehot = (dig_in != '0) && ((dig_in & (dig_in - 4'd1)) == '0);
   assign s_multi_hot   = (s_dig & (s_dig - 4'd1)) != '0;

   // Stability is judged between the value being sampled and the held sample, so
   // the counter reaches STABLE_CYCLES on the (STABLE_CYCLES+1)th edge of a dwell.
   assign stable    = dig_in_onehot && (ssd_in == s_ssd) && (dig_in == s_dig);
   assign capture   = stable && (stab_cnt == STABLE_PRE);
   assign seen_next = seen | s_dig;

   seg7_glyph_decode u_glyph_decode (
      .pattern  (s_ssd),
      .hit      (dec_hit),
      .is_blank (dec_blank),
      .nibble   (dec_nibble)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ssd    <= '0;
         s_dig    <= '0;
         stab_cnt <= '0;
      end else begin
         s_ssd <= ssd_in;
         s_dig <= dig_in;
         if (!stable) begin
            stab_cnt <= '0;
         end else if (stab_cnt != STABLE_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_err_cnt <= '0;
      end else if (s_multi_hot && (scan_err_cnt != '1)) begin
         scan_err_cnt <= scan_err_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value        <= '0;
         valid        <= '0;
         blank        <= '0;
         bad_glyph    <= '0;
         seen         <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= 1'b0;
         if (capture) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (s_dig[i]) begin
                  valid[i]     <= dec_hit;
                  blank[i]     <= !dec_hit && dec_blank;
                  bad_glyph[i] <= !dec_hit && !dec_blank;
                  if (dec_hit) begin
                     value[4*i +: 4] <= dec_nibble;
                  end
               end
            end
            if (seen_next == '1) begin
               frame_strobe <= 1'b1;
               seen         <= '0;
            end else begin
               seen <= seen_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Randomised and directed bench for ssd_scan_decoder against a run-length
// reference model of the display scan.
module tb_ssd_scan_decoder;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  ssd = 7'h7F;
   logic [3:0]  dig = 4'hF;
   logic [15:0] value;
   logic [3:0]  valid, blank, bad_glyph;
   logic        frame_strobe;
   logic [7:0]  scan_err_cnt;

   ssd_scan_decoder #(
      .STABLE_CYCLES  (STABLE),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ssd          (ssd),
      .dig          (dig),
      .value        (value),
      .valid        (valid),
      .blank        (blank),
      .bad_glyph    (bad_glyph),
      .frame_strobe (frame_strobe),
      .scan_err_cnt (scan_err_cnt)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [15:0] m_value;
   logic [3:0]  m_valid, m_blank, m_bad, m_seen;
   logic        m_strobe;
   int          m_err;
   int          m_run;
   logic        m_last_ok;
   logic [6:0]  m_last_ssd;
   logic [3:0]  m_last_dig;
   logic        m_prev_multi;
   int          strobe_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_value = '0; m_valid = '0; m_blank = '0; m_bad = '0; m_seen = '0;
      m_strobe = 1'b0; m_err = 0; m_run = 0; m_last_ok = 1'b0;
      m_last_ssd = '0; m_last_dig = '0; m_prev_multi = 1'b0;
   endtask

   // One clock edge of the display as seen by an observer: a digit is read once
   // the same one-hot pattern has been presented for STABLE+1 consecutive edges.
   task automatic model_edge(input logic [6:0] seg, input logic [3:0] d);
      int idx;
      int hit;
      m_strobe = 1'b0;
      if (m_prev_multi && m_err < 255) m_err++;
      m_prev_multi = ($countones(d) > 1);
      if (m_last_ok && seg == m_last_ssd && d == m_last_dig && $countones(d) == 1)
         m_run++;
      else
         m_run = ($countones(d) == 1) ? 1 : 0;
      m_last_ok  = 1'b1;
      m_last_ssd = seg;
      m_last_dig = d;
      if (m_run == STABLE + 1) begin
         idx = 0;
         for (int k = 0; k < 4; k++) if (d[k]) idx = k;
         hit = -1;
         for (int g = 0; g < 16; g++) if (glyph_tab[g] == seg) hit = g;
         if (hit >= 0) begin
            m_value[4*idx +: 4] = 4'(hit);
            m_valid[idx] = 1'b1; m_blank[idx] = 1'b0; m_bad[idx] = 1'b0;
         end else if (seg == 7'h00) begin
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b1; m_bad[idx] = 1'b0;
         end else begin
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; m_bad[idx] = 1'b1;
         end
         m_seen = m_seen | d;
         if (m_seen == 4'hF) begin
            m_strobe = 1'b1;
            m_seen   = '0;
         end
      end
   endtask

   task automatic compare_all();
      check("value", 32'(value), 32'(m_value));
      check("valid", 32'(valid), 32'(m_valid));
      check("blank", 32'(blank), 32'(m_blank));
      check("bad_glyph", 32'(bad_glyph), 32'(m_bad));
      check("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
      check("scan_err_cnt", 32'(scan_err_cnt), 32'(m_err));
   endtask

   // seg and d are active-high; the DUT is driven with the default active-low polarity
   task automatic cycle(input logic [6:0] seg, input logic [3:0] d);
      ssd = ~seg;
      dig = ~d;
      @(posedge clk);
      model_edge(seg, d);
      #1;
      if (frame_strobe === 1'b1) strobe_seen++;
      compare_all();
   endtask

   task automatic hold(input logic [6:0] seg, input logic [3:0] d, input int n);
      for (int c = 0; c < n; c++) cycle(seg, d);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] d;
      logic [6:0] seg;
      int         r;

      model_reset();
      strobe_seen = 0;
      @(posedge clk);
      do_reset();

      // single digit-0 capture of glyph 2 after five edges
      hold(7'h5B, 4'b0001, 4);
      check("pre_capture_valid", 32'(valid), 32'h0);
      cycle(7'h5B, 4'b0001);
      check("digit0_value", 32'(value[3:0]), 32'h2);
      check("digit0_valid", 32'(valid), 32'h1);
      check("digit0_strobe", 32'(frame_strobe), 32'h0);

      // full scan 1,A,d,F
      strobe_seen = 0;
      hold(7'h06, 4'b0001, 6);
      hold(7'h77, 4'b0010, 6);
      hold(7'h5E, 4'b0100, 6);
      hold(7'h71, 4'b1000, 6);
      check("frame_value", 32'(value), 32'hFDA1);
      check("frame_valid", 32'(valid), 32'hF);
      check("frame_strobes", 32'(strobe_seen), 32'd1);

      // short dwell on digit 2 must not capture
      hold(7'h3F, 4'b0100, 3);
      check("short_dwell_value", 32'(value), 32'hFDA1);

      // digit 1 blank, then non-hex pattern
      hold(7'h00, 4'b0010, 5);
      check("blank1", 32'(blank[1]), 32'h1);
      hold(7'h2A, 4'b0010, 5);
      check("bad1", 32'(bad_glyph[1]), 32'h1);
      check("bad1_valid", 32'(valid[1]), 32'h0);
      check("bad1_nibble", 32'(value[7:4]), 32'hA);

      // no enable: neither capture nor error
      hold(7'h06, 4'b0000, 8);

      // multi-hot enables saturate the error counter
      hold(7'h3F, 4'b1100, 300);
      check("err_saturated", 32'(scan_err_cnt), 32'd255);

      // reset mid-dwell aborts it; a fresh full dwell is required afterwards
      hold(7'h66, 4'b0001, 2);
      do_reset();
      check("reset_value", 32'(value), 32'h0);
      check("reset_err", 32'(scan_err_cnt), 32'h0);
      hold(7'h66, 4'b0001, 4);
      check("post_reset_early", 32'(valid), 32'h0);
      cycle(7'h66, 4'b0001);
      check("post_reset_capture", 32'(value[3:0]), 32'h4);

      // randomised dwells
      for (int t = 0; t < 80; t++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      d = 4'($urandom_range(0, 15));
         else             d = 4'(1 << $urandom_range(0, 3));
         r = int'($urandom_range(0, 9));
         if (r == 0)      seg = 7'h00;
         else if (r == 1) seg = 7'($urandom);
         else             seg = glyph_tab[$urandom_range(0, 15)];
         hold(seg, d, int'($urandom_range(1, 8)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ssd_scan_decoder.md
SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (legal range 1..255).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1: segment lines are active-low.
REQ-003 SHALL have parameter DIG_ACTIVE_LOW, default 1: digit enables are active-low.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ssd  input  7  multiplexed segment lines, bit0=a .. bit6=g.
REQ-007 dig  input  4  digit enables, bit0 = rightmost digit.
REQ-008 value  output  16  decoded nibbles, value[4i+3:4i] = digit i.
REQ-009 valid  output  4  digit i holds a legal hex glyph.
REQ-010 blank  output  4  digit i last captured all-segments-off.
REQ-011 bad_glyph  output  4  digit i last captured a non-hex, non-blank pattern.
REQ-012 frame_strobe  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
REQ-013 scan_err_cnt  output  8  saturating count of multi-hot dig samples.

Function
REQ-014 SHALL register ssd and dig once (sample stage), normalising both to active-high using the polarity parameters.
REQ-015 SHALL keep a stability counter: cleared to 0 when the sampled {ssd,dig} differs from the previous sample or the sampled dig is not one-hot; otherwise incremented, saturating at STABLE_CYCLES.
REQ-016 SHALL capture exactly once per dwell, in the cycle the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES; capture results SHALL be visible STABLE_CYCLES+1 rising edges after a held input change.
REQ-017 Capture to digit i (one-hot bit i) SHALL decode via the hex table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (active-high, bit0=a).
REQ-018 On a table match: value nibble i <= decoded nibble, valid[i]=1, blank[i]=0, bad_glyph[i]=0.
REQ-019 On pattern 00: blank[i]=1, valid[i]=0, bad_glyph[i]=0, value nibble i unchanged.
REQ-020 Any other pattern: bad_glyph[i]=1, valid[i]=0, blank[i]=0, value nibble i unchanged.
REQ-021 All-zero dig SHALL neither capture nor count as an error.
REQ-022 A seen mask SHALL set bit i on every capture; when a capture makes the mask 1111, frame_strobe SHALL pulse that same cycle the outputs update and the mask SHALL clear to 0000 (capturing bit included).
REQ-023 Re-capturing an already-seen digit SHALL update its outputs without a frame_strobe.
REQ-024 scan_err_cnt SHALL increment every cycle the sampled dig has more than one active bit, saturating at 255.
REQ-025 Inputs changing before the dwell completes SHALL produce no capture and no output change.

Reset
REQ-026 While rst=1: value=0000, valid=0000, blank=0000, bad_glyph=0000, frame_strobe=0, scan_err_cnt=0, seen mask=0, counter=0, sample regs = inactive (all-off after normalisation).
REQ-027 Reset asserted mid-dwell SHALL abort it; after release a full new dwell is required before any capture.

Structure
REQ-028 Package ssd_pkg SHALL hold the 16 glyph constants, segment bit indices and the blank pattern constant.
REQ-029 Sub-module seg7_glyph_decode (combinational: 7-bit pattern -> {hit, is_blank, nibble}) SHALL be used for REQ-017..020.

Verification
REQ-030 Defaults; dig=1110, ssd=~7'h5B held 5 cycles -> after 5th edge value[3:0]=2, valid=0001, no frame_strobe.
REQ-031 Scan digits 0..3 with glyphs 1,A,d,F, 6 cycles each -> value=F_D_A_1 (16'hFDA1), valid=1111, single frame_strobe on 4th capture, mask cleared.
REQ-032 Digit 2 dwell of 3 cycles only -> no change to value/valid for digit 2.
REQ-033 Digit 1 pattern 00 then 7'h2A, 5 cycles each -> blank[1]=1, then bad_glyph[1]=1, valid[1]=0, value nibble 1 kept.
REQ-034 dig=1100 held 300 cycles -> scan_err_cnt saturates at 255, no capture.
REQ-035 rst pulsed at cycle 2 of a dwell -> all outputs 0; capture occurs only 5 edges after release with input held.
